// File: rtl/fwd_sel_unit_if.sv
// Bundle of the ID-stage hazard inputs and the EX operand-select / stall outputs.
// When FWD_STATS_EN is defined it also carries the stall and forward counters.
interface fwd_sel_unit_if #(
  parameter int unsigned RA_W = 5
);
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic [RA_W-1:0] id_dst;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            flush;
  logic [1:0]      ex_a_sel;
  logic [1:0]      ex_b_sel;
  logic            stall_id;
`ifdef FWD_STATS_EN
  logic [15:0]     stall_cnt;
  logic [15:0]     fwd_cnt;
`endif

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_write, id_mem_read, flush,
`ifdef FWD_STATS_EN
    input  stall_cnt, fwd_cnt,
`endif
    input  ex_a_sel, ex_b_sel, stall_id
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_write, id_mem_read, flush,
`ifdef FWD_STATS_EN
    output stall_cnt, fwd_cnt,
`endif
    output ex_a_sel, ex_b_sel, stall_id
  );
endinterface

// File: rtl/fwd_sel_unit.sv
// EX-stage forwarding select and load-use stall generator.
// Optional FWD_STATS_EN adds saturating stall_cnt / fwd_cnt counters.
module fwd_sel_unit #(
  parameter int unsigned RA_W   = 5,
  parameter int unsigned ZERO_R = 0
) (
  input logic           Clk,
  input logic           Rst,
  fwd_sel_unit_if.slave bus
);

  localparam logic [RA_W-1:0] ZeroR = RA_W'(ZERO_R);

  logic [RA_W-1:0] ex_rs_q, ex_rt_q, ex_dst_q, mem_dst_q, wb_dst_q;
  logic            ex_rw_q, ex_mr_q, mem_rw_q, wb_rw_q;
  logic            stall_raw;
  logic [1:0]      a_sel, b_sel;

  // Newest producer (MEM) wins over the older one (WB).
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic            m_rw,
    input logic [RA_W-1:0] m_dst,
    input logic            w_rw,
    input logic [RA_W-1:0] w_dst
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_rw && (m_dst != ZeroR) && (m_dst == src)) begin
      sel = 2'b10;
    end else if (w_rw && (w_dst != ZeroR) && (w_dst == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    stall_raw = ex_mr_q && (ex_dst_q != ZeroR) &&
                ((bus.id_use_rs && (ex_dst_q == bus.id_rs)) ||
                 (bus.id_use_rt && (ex_dst_q == bus.id_rt))) && !bus.flush;
    a_sel = fwd_sel(ex_rs_q, mem_rw_q, mem_dst_q, wb_rw_q, wb_dst_q);
    b_sel = fwd_sel(ex_rt_q, mem_rw_q, mem_dst_q, wb_rw_q, wb_dst_q);
    bus.ex_a_sel = Rst ? 2'b00 : a_sel;
    bus.ex_b_sel = Rst ? 2'b00 : b_sel;
    bus.stall_id = Rst ? 1'b0 : stall_raw;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ex_rs_q   <= '0;
      ex_rt_q   <= '0;
      ex_dst_q  <= '0;
      ex_rw_q   <= 1'b0;
      ex_mr_q   <= 1'b0;
      mem_dst_q <= '0;
      mem_rw_q  <= 1'b0;
      wb_dst_q  <= '0;
      wb_rw_q   <= 1'b0;
    end else begin
      wb_dst_q  <= mem_dst_q;
      wb_rw_q   <= mem_rw_q;
      mem_dst_q <= ex_dst_q;
      mem_rw_q  <= ex_rw_q;
      if (stall_raw || bus.flush) begin
        ex_rs_q  <= '0;
        ex_rt_q  <= '0;
        ex_dst_q <= '0;
        ex_rw_q  <= 1'b0;
        ex_mr_q  <= 1'b0;
      end else begin
        // Unused sources are parked on the zero register so they never match.
        ex_rs_q  <= bus.id_use_rs ? bus.id_rs : ZeroR;
        ex_rt_q  <= bus.id_use_rt ? bus.id_rt : ZeroR;
        ex_dst_q <= bus.id_dst;
        ex_rw_q  <= bus.id_reg_write;
        ex_mr_q  <= bus.id_mem_read;
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_raw && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (((a_sel != 2'b00) || (b_sel != 2'b00)) && (fwd_cnt_q != 16'hFFFF)) begin
        fwd_cnt_q <= fwd_cnt_q + 16'd1;
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Directed hazard scenarios followed by randomized traffic, checked against a
// pipeline-occupancy reference model.
module tb_fwd_sel_unit;
  localparam int unsigned RA_W = 5;

  typedef struct {
    int unsigned rs;
    int unsigned rt;
    int unsigned dst;
    bit          rw;
    bit          mr;
  } instr_t;

  logic Clk = 1'b0;
  logic Rst;
  int   checks = 0;
  int   errors = 0;

  // Reference pipeline: slot 0 = EX, 1 = MEM, 2 = WB.
  instr_t pipe[3];
  int unsigned exp_stall_cnt, exp_fwd_cnt;

  fwd_sel_unit_if #(.RA_W(RA_W)) bus ();

  fwd_sel_unit #(.RA_W(RA_W), .ZERO_R(0)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  function automatic int unsigned ref_sel(input int unsigned r);
    if (Rst || r == 0) return 0;
    if (pipe[1].rw && pipe[1].dst == r) return 2;
    if (pipe[2].rw && pipe[2].dst == r) return 1;
    return 0;
  endfunction

  function automatic bit ref_stall();
    if (Rst || bus.flush || !pipe[0].mr || pipe[0].dst == 0) return 0;
    return (bus.id_use_rs && pipe[0].dst == bus.id_rs) ||
           (bus.id_use_rt && pipe[0].dst == bus.id_rt);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int unsigned rs, input bit urs, input int unsigned rt, input bit urt,
                       input int unsigned dst, input bit rw, input bit mr, input bit fl);
    bus.id_rs        = RA_W'(rs);
    bus.id_use_rs    = urs;
    bus.id_rt        = RA_W'(rt);
    bus.id_use_rt    = urt;
    bus.id_dst       = RA_W'(dst);
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.flush        = fl;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Compare everything against the model at the falling edge.
  task automatic settle();
    @(negedge Clk);
    chk("model_a_sel", {14'd0, bus.ex_a_sel}, 16'(ref_sel(pipe[0].rs)));
    chk("model_b_sel", {14'd0, bus.ex_b_sel}, 16'(ref_sel(pipe[0].rt)));
    chk("model_stall", {15'd0, bus.stall_id}, 16'(ref_stall()));
`ifdef FWD_STATS_EN
    chk("model_stall_cnt", bus.stall_cnt, 16'(exp_stall_cnt));
    chk("model_fwd_cnt", bus.fwd_cnt, 16'(exp_fwd_cnt));
`endif
  endtask

  task automatic adv();
    bit     st;
    bit     fw;
    instr_t nx;
    st = ref_stall();
    fw = (ref_sel(pipe[0].rs) != 0) || (ref_sel(pipe[0].rt) != 0);
    @(posedge Clk);
    if (Rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
      exp_stall_cnt = 0;
      exp_fwd_cnt   = 0;
    end else begin
      if (st && exp_stall_cnt < 16'hFFFF) exp_stall_cnt++;
      if (fw && exp_fwd_cnt < 16'hFFFF) exp_fwd_cnt++;
      nx = '{0, 0, 0, 0, 0};
      if (!st && !bus.flush) begin
        nx.rs  = bus.id_use_rs ? int'(bus.id_rs) : 0;
        nx.rt  = bus.id_use_rt ? int'(bus.id_rt) : 0;
        nx.dst = bus.id_dst;
        nx.rw  = bus.id_reg_write;
        nx.mr  = bus.id_mem_read;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nx;
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic expect_out(input string tag, input logic [1:0] a, input logic [1:0] b,
                            input logic s);
    chk({tag, "_a"}, {14'd0, bus.ex_a_sel}, {14'd0, a});
    chk({tag, "_b"}, {14'd0, bus.ex_b_sel}, {14'd0, b});
    chk({tag, "_stall"}, {15'd0, bus.stall_id}, {15'd0, s});
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
    exp_stall_cnt = 0;
    exp_fwd_cnt   = 0;
    Rst = 1'b1;
    nop();
    cyc();
    cyc();
    Rst = 1'b0;
    settle();
    expect_out("reset", 2'b00, 2'b00, 1'b0);
    adv();

    // EX->EX forward from MEM
    drive(0, 0, 0, 0, 3, 1, 0, 0);  cyc();
    drive(3, 1, 1, 1, 8, 1, 0, 0);  cyc();
    nop(); settle(); expect_out("t1_mem_fwd", 2'b10, 2'b00, 1'b0); adv();

    // Forward from WB on rt
    drive(0, 0, 0, 0, 4, 1, 0, 0);  cyc();
    nop();                          cyc();
    drive(2, 1, 4, 1, 9, 1, 0, 0);  cyc();
    nop(); settle(); expect_out("t2_wb_fwd", 2'b00, 2'b01, 1'b0); adv();

    // Back-to-back writers: MEM wins over WB
    drive(0, 0, 0, 0, 7, 1, 0, 0);  cyc();
    drive(0, 0, 0, 0, 7, 1, 0, 0);  cyc();
    drive(7, 1, 0, 0, 10, 1, 0, 0); cyc();
    nop(); settle(); expect_out("t3_mem_wins", 2'b10, 2'b00, 1'b0); adv();
    nop(); cyc(); cyc(); cyc();

    // Load-use: one stall, bubble, then WB forward
    drive(0, 0, 0, 0, 5, 1, 1, 0);  cyc();
    drive(5, 1, 0, 0, 11, 1, 0, 0);
    settle(); expect_out("t4_stall", 2'b00, 2'b00, 1'b1); adv();
    settle(); expect_out("t4_bubble", 2'b00, 2'b00, 1'b0); adv();
    nop(); settle(); expect_out("t4_after", 2'b01, 2'b00, 1'b0); adv();
    nop(); cyc(); cyc(); cyc();

    // Zero register never forwards or stalls
    drive(0, 0, 0, 0, 0, 1, 1, 0);  cyc();
    drive(0, 1, 0, 1, 12, 1, 0, 0);
    settle(); expect_out("t5_zero_id", 2'b00, 2'b00, 1'b0); adv();
    nop(); settle(); expect_out("t5_zero_ex", 2'b00, 2'b00, 1'b0); adv();
    nop(); cyc(); cyc(); cyc();

    // Flush beats load-use stall and bubbles EX
    drive(0, 0, 0, 0, 5, 1, 1, 0);  cyc();
    drive(5, 1, 0, 0, 13, 1, 0, 1);
    settle(); expect_out("t6_flush", 2'b00, 2'b00, 1'b0); adv();
    nop(); settle(); expect_out("t6_bubble", 2'b00, 2'b00, 1'b0); adv();
    nop(); cyc(); cyc(); cyc();

    // Reset mid-stream
    drive(0, 0, 0, 0, 9, 1, 0, 0);  cyc();
    drive(9, 1, 9, 1, 14, 1, 0, 0); cyc();
    nop(); Rst = 1'b1;
    settle(); expect_out("rst_forced", 2'b00, 2'b00, 1'b0); adv();
    Rst = 1'b0;
    settle(); expect_out("rst_after", 2'b00, 2'b00, 1'b0); adv();

    // Randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
            $urandom_range(0, 7), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0));
      Rst = ($urandom_range(0, 63) == 0);
      cyc();
    end
    Rst = 1'b0;
    nop();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
